// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
// TDM_RX_PARITY_EN adds a trailing even-parity slot to each frame.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    localparam int TDM_NUM_CH_DEFAULT     = 4;
    localparam int TDM_MISS_LIMIT_DEFAULT = 3;

    // Index of the final slot of a frame.
    function automatic int tdm_last(input int num_ch);
`ifdef TDM_RX_PARITY_EN
        return num_ch;
`else
        return num_ch - 1;
`endif
    endfunction

endpackage

// File: rtl/tdm_demux_rx_if.sv
// Serial-in / parallel-out bundle of the TDM receiver.
// Master drives the serial side, slave is the receiver.
interface tdm_demux_rx_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = TDM_NUM_CH_DEFAULT
);
    localparam int SW = $clog2(NUM_CH + 1);

    logic              bit_valid;
    logic              serial_in;
    logic              frame_sync;
    logic [NUM_CH-1:0] data_out;
    logic              frame_valid;
    logic              locked;
    logic [SW-1:0]     slot;
    logic              sync_err;
    logic              parity_err;

    modport master (
        output bit_valid, serial_in, frame_sync,
        input  data_out, frame_valid, locked, slot,
        input  sync_err, parity_err
    );

    modport slave (
        input  bit_valid, serial_in, frame_sync,
        output data_out, frame_valid, locked, slot,
        output sync_err, parity_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot counter: wraps to 0 after LAST, with load-to-1 and clear.
// Clear beats load, load beats count enable.
module tdm_slot_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load1,
    input  logic             clr,
    output logic [WIDTH-1:0] slot,
    output logic             is_last
);

    logic [WIDTH-1:0] slot_q;
    logic [WIDTH-1:0] slot_d;

    assign slot    = slot_q;
    assign is_last = (slot_q == WIDTH'(LAST));

    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = WIDTH'(1);
        end else if (en) begin
            slot_d = is_last ? '0 : slot_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer with flywheel frame lock.
// TDM_RX_PARITY_EN enables the trailing even-parity slot check.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int NUM_CH     = TDM_NUM_CH_DEFAULT,
    parameter int MISS_LIMIT = TDM_MISS_LIMIT_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_rx_if.slave  bus
);

    localparam int SW   = $clog2(NUM_CH + 1);
    localparam int MW   = $clog2(MISS_LIMIT + 1);
    localparam int LAST = tdm_last(NUM_CH);

    state_e            state_q, state_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic [NUM_CH-1:0] cap_q, cap_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              fv_q, fv_d;
    logic              se_q, se_d;
    logic              pe_q, pe_d;

    logic              cnt_en, cnt_load, cnt_clr;
    logic [SW-1:0]     slot;
    logic              is_last;
    logic [NUM_CH-1:0] word;

    tdm_slot_counter #(
        .WIDTH (SW),
        .LAST  (LAST)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .en      (cnt_en),
        .load1   (cnt_load),
        .clr     (cnt_clr),
        .slot    (slot),
        .is_last (is_last)
    );

    // Capture word with the current bit merged in; the parity slot
    // matches no channel index and so leaves the data bits alone.
    always_comb begin
        word = cap_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot == SW'(i)) word[i] = bus.serial_in;
        end
    end

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        cap_d    = cap_q;
        data_d   = data_q;
        fv_d     = 1'b0;
        se_d     = 1'b0;
        pe_d     = 1'b0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        if (bus.bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_d  = LOCKED;
                        cap_d    = NUM_CH'(bus.serial_in);
                        miss_d   = '0;
                        cnt_load = 1'b1;
                    end
                end
                LOCKED: begin
                    if (bus.frame_sync && slot != '0) begin
                        se_d     = 1'b1;
                        cap_d    = NUM_CH'(bus.serial_in);
                        miss_d   = '0;
                        cnt_load = 1'b1;
                    end else if (slot == '0) begin
                        if (bus.frame_sync
                            || miss_q != MW'(MISS_LIMIT - 1)) begin
                            cap_d    = NUM_CH'(bus.serial_in);
                            miss_d   = bus.frame_sync ? '0
                                     : miss_q + MW'(1);
                            cnt_load = 1'b1;
                        end else begin
                            state_d = HUNT;
                            miss_d  = '0;
                            cnt_clr = 1'b1;
                        end
                    end else begin
                        cap_d  = word;
                        cnt_en = 1'b1;
                        if (is_last) begin
                            data_d = word;
                            fv_d   = 1'b1;
`ifdef TDM_RX_PARITY_EN
                            pe_d   = ^word ^ bus.serial_in;
`endif
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            miss_q  <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
            pe_q    <= pe_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.frame_valid = fv_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.slot        = slot;
    assign bus.sync_err    = se_q;
`ifdef TDM_RX_PARITY_EN
    assign bus.parity_err  = pe_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Randomized bench for tdm_demux_rx against a frame-level reference model.
// Builds with or without TDM_RX_PARITY_EN.
module tb_tdm_demux_rx;
    import tdm_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ML     = 3;
`ifdef TDM_RX_PARITY_EN
    localparam int LASTM  = NUM_CH;
`else
    localparam int LASTM  = NUM_CH - 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_rx_if #(.NUM_CH(NUM_CH)) bus ();

    tdm_demux_rx #(
        .NUM_CH     (NUM_CH),
        .MISS_LIMIT (ML)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame position, lock flag, missed-sync count
    // and the channel bits gathered so far.
    int                m_lock, m_pos, m_miss;
    bit                m_bits [NUM_CH];
    logic [NUM_CH-1:0] e_data;
    logic              e_fv, e_se, e_pe;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_lock = 0;
        m_pos  = 0;
        m_miss = 0;
        foreach (m_bits[i]) m_bits[i] = 1'b0;
        e_data = '0;
        e_fv   = 1'b0;
        e_se   = 1'b0;
        e_pe   = 1'b0;
    endfunction

    function automatic void start_frame(input bit s);
        foreach (m_bits[i]) m_bits[i] = 1'b0;
        m_bits[0] = s;
        m_pos     = 1;
    endfunction

    function automatic void model_bit(input bit s, input bit fs);
        bit par;
        if (m_lock == 0) begin
            if (fs) begin
                m_lock = 1;
                m_miss = 0;
                start_frame(s);
            end
        end else if (fs && m_pos != 0) begin
            e_se   = 1'b1;
            m_miss = 0;
            start_frame(s);
        end else if (m_pos == 0) begin
            if (fs) begin
                m_miss = 0;
                start_frame(s);
            end else if (m_miss + 1 < ML) begin
                m_miss++;
                start_frame(s);
            end else begin
                m_lock = 0;
                m_miss = 0;
            end
        end else begin
            if (m_pos < NUM_CH) m_bits[m_pos] = s;
            if (m_pos == LASTM) begin
                par = s;
                for (int i = 0; i < NUM_CH; i++) begin
                    e_data[i] = m_bits[i];
                    par ^= m_bits[i];
                end
                e_fv = 1'b1;
`ifdef TDM_RX_PARITY_EN
                e_pe = par;
`endif
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endfunction

    task automatic check_all();
        chk("data_out",    32'(bus.data_out),    32'(e_data));
        chk("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
        chk("locked",      32'(bus.locked),      32'(m_lock));
        chk("slot",        32'(bus.slot),        32'(m_pos));
        chk("sync_err",    32'(bus.sync_err),    32'(e_se));
        chk("parity_err",  32'(bus.parity_err),  32'(e_pe));
    endtask

    task automatic step(input bit v, input bit s, input bit fs);
        @(negedge clk);
        bus.bit_valid  = v;
        bus.serial_in  = s;
        bus.frame_sync = fs;
        @(posedge clk);
        e_fv = 1'b0;
        e_se = 1'b0;
        e_pe = 1'b0;
        if (v) model_bit(s, fs);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [NUM_CH-1:0] d, input bit fs,
                              input bit gaps, input bit bad_par);
        bit s;
        for (int i = 0; i <= LASTM; i++) begin
            if (gaps) step(1'b0, 1'($urandom), 1'($urandom));
            s = (i < NUM_CH) ? d[i] : (^d ^ bad_par);
            step(1'b1, s, (i == 0) && fs);
        end
    endtask

    initial begin
        bus.bit_valid  = 1'b0;
        bus.serial_in  = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();
        do_reset();

        send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
        chk("plan_cont", 32'(bus.data_out), 32'hD);
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
        send_frame(4'b1101, 1'b1, 1'b1, 1'b0);
        chk("plan_gaps", 32'(bus.data_out), 32'hD);

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("plan_serr", 32'(bus.sync_err), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
`ifdef TDM_RX_PARITY_EN
        step(1'b1, 1'b0, 1'b0);
`endif
        chk("plan_realign", 32'(bus.data_out), 32'hC);

        send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
        chk("plan_fly", 32'(bus.locked), 32'h1);
        send_frame(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1001, 1'b1, 1'b0, 1'b0);

        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
        chk("plan_rst", 32'(bus.data_out), 32'hD);

`ifdef TDM_RX_PARITY_EN
        send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
        chk("plan_par_ok", 32'(bus.parity_err), 32'h0);
        send_frame(4'b1101, 1'b1, 1'b0, 1'b1);
        chk("plan_par_bad", 32'(bus.parity_err), 32'h1);
`endif

        for (int n = 0; n < 4000; n++) begin
            bit v, s, fs;
            if ($urandom_range(599) == 0) do_reset();
            v  = ($urandom_range(9) < 7);
            s  = 1'($urandom);
            if (m_lock != 0 && m_pos == 0) fs = ($urandom_range(7) != 0);
            else if (m_lock != 0)          fs = ($urandom_range(39) == 0);
            else                           fs = ($urandom_range(3) == 0);
            step(v, s, fs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the simple comm system's time-division link: the transmit side multiplexes NUM_CH data bits onto one serial line, one slot per bit-time.
- This block recovers frame alignment from a frame-sync strobe, steers each serial bit to its channel, and presents a complete parallel word with a one-cycle valid pulse.
- Its flywheel lock FSM tolerates isolated missing sync strobes.

Parameters:
- NUM_CH, 4, channels per frame (>=2); slot counter width is $clog2(NUM_CH+1).
- MISS_LIMIT, 3, consecutive frames without frame_sync at slot 0 before lock is dropped (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- bit_valid  in  1  qualifies serial_in/frame_sync this cycle; all state advances only when high.
- serial_in  in  1  TDM serial data bit.
- frame_sync  in  1  high with the slot-0 bit of a frame; ignored when bit_valid=0.
- data_out  out  NUM_CH  last complete frame; bit i = channel i.
- frame_valid  out  1  one-cycle pulse; data_out updated on the same edge.
- locked  out  1  high in LOCKED state.
- slot  out  $clog2(NUM_CH+1)  slot index expected for the next valid bit.
- sync_err  out  1  one-cycle pulse on misplaced frame_sync.
- parity_err  out  1  one-cycle pulse; tied 0 when feature absent.

Behaviour:
- Reset (async assert, sync release): state=HUNT; data_out=0; frame_valid=0; locked=0; slot=0; sync_err=0; parity_err=0; miss_cnt=0; shift register=0.
- frame_valid, sync_err and parity_err default to 0 every cycle; they pulse only as stated below.
- Cycles with bit_valid=0: no state change; pulses still clear.
- HUNT:
  - bit_valid&&frame_sync: capture serial_in as ch0; slot<=1; miss_cnt<=0; go LOCKED.
  - Otherwise stay in HUNT; bits are discarded.
- LOCKED, on each bit_valid:
  - frame_sync && slot!=0: sync_err pulse; discard partial frame; capture serial_in as ch0; slot<=1; miss_cnt<=0 (re-align, stay LOCKED).
  - slot==0 && frame_sync: capture ch0; miss_cnt<=0; slot<=1.
  - slot==0 && !frame_sync, miss_cnt+1 < MISS_LIMIT (flywheel): capture ch0; miss_cnt++; slot<=1.
  - slot==0 && !frame_sync, miss_cnt+1 == MISS_LIMIT: go HUNT; slot<=0; miss_cnt<=0; bit discarded.
  - 0<slot<LAST: capture into ch[slot]; slot++.
  - slot==LAST: data_out<=assembled word including this bit; frame_valid pulse; slot<=0 (wrap).
- LAST = NUM_CH-1 without the optional feature, NUM_CH with it.
- Latency: data_out and frame_valid are registered on the edge that samples the final slot bit, so they are visible the following cycle. Between frames, data_out holds its value.
- data_out is never partially updated; aborted frames leave it unchanged.
- Back-to-back frames with continuous bit_valid are supported: one frame_valid every LAST+1 valid bits.
- Reset mid-frame discards everything and returns to HUNT.

Optional Feature:
- Macro: TDM_RX_PARITY_EN.
- Defined: each frame carries one extra slot (index NUM_CH) holding an even-parity bit over channels 0..NUM_CH-1.
  - At that slot: data_out updates and frame_valid pulses as normal.
  - parity_err pulses in the same cycle if XOR(data bits, parity bit)=1.
  - Lock state is unaffected by parity errors.
- Undefined: frame is NUM_CH slots; parity_err is constant 0.

Decomposition:
- Package tdm_pkg: state enum {HUNT, LOCKED}; TDM_NUM_CH_DEFAULT=4; TDM_MISS_LIMIT_DEFAULT=3.
- Sub-module tdm_slot_counter: wrap-around counter with enable, sync load-to-1 and clear. Wrap point is LAST; it provides slot and an is_last flag.
- FSM, capture register and output register stay in tdm_demux_rx.

Test Plan:
- Reset then frame 1,0,1,1 (ch0..ch3, frame_sync with ch0), bit_valid continuous -> locked=1 after first bit; frame_valid one cycle after 4th bit; data_out=4'b1101.
- Same frame with bit_valid toggling 1,0,1,0 -> identical data_out=4'b1101; frame_valid only after the 4th valid bit.
- While LOCKED, frame_sync at slot 2 -> sync_err pulses once; next 3 bits 0,1,1 complete a frame; data_out = {1,1,0,new ch0}.
- Omit frame_sync for 2 frames -> frames still delivered, locked=1. Omit for 3 consecutive frames -> locked=0 at the 3rd missing slot 0, no frame_valid for that frame.
- Assert rst after 2 bits of a frame -> all outputs 0 immediately (async). After release, a full frame with sync gives the correct data_out.
- TDM_RX_PARITY_EN defined: frame 1,0,1,1 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 -> parity_err pulses with frame_valid; data_out=4'b1101 either way.
